// File: rtl/cmp_toggle_tracker.sv
`default_nettype none
// ============================================================================
// Module      : cmp_toggle_tracker
// Description : Compares two WIDTH-bit operands on every enabled cycle and
//               reports the relation (GT / EQ / LT) in several forms:
//                 - q      : 2-bit status. In toggle mode it behaves as a pair
//                            of T flip-flops. In level mode it holds the
//                            relation as flags.
//                 - rel    : encoded last sampled relation
//                 - *_cnt  : saturating per-relation event counters
//                 - stable : high once one relation has been sampled
//                            STABLE_N times in a row (en=0 cycles do not
//                            break a run)
//               All outputs are registered and show the sample one cycle
//               after the enabled edge.
//
// Ports       : clk     - clock, rising edge
//               reset   - synchronous active-high reset
//               en      - sample enable; when low all state holds
//               clr     - synchronous clear of q, rel, counters and FSM
//               mode    - 0 = toggle mode, 1 = level mode
//               a, b    - operands [WIDTH-1:0]
//               q       - q[0] follows GT, q[1] follows EQ
//               rel     - 2'b01 GT, 2'b10 EQ, 2'b00 LT
//               gt_cnt, eq_cnt, lt_cnt - saturating counters [CNT_W-1:0]
//               stable  - high while the run-length FSM is in STABLE
//
// Options     : CMP_SIGNED_EN - when defined, a and b are compared as
//               two's-complement signed values; otherwise unsigned.
//
// Revision    : 1.0 - initial release
// ============================================================================
module cmp_toggle_tracker #(
    parameter int WIDTH    = 4,
    parameter int CNT_W    = 8,
    parameter int STABLE_N = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [1:0]       q,
    output logic [1:0]       rel,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] lt_cnt,
    output logic             stable
);

    localparam int                 c_RUN_W      = $clog2(STABLE_N + 1);
    localparam logic [c_RUN_W-1:0] c_RUN_ONE    = c_RUN_W'(1);
    localparam logic [c_RUN_W-1:0] c_RUN_TARGET = c_RUN_W'(STABLE_N);
    localparam logic [CNT_W-1:0]   c_CNT_MAX    = {CNT_W{1'b1}};
    localparam logic               c_ONE_SHOT   = (STABLE_N == 1);

    localparam logic [1:0] c_REL_LT = 2'b00;
    localparam logic [1:0] c_REL_GT = 2'b01;
    localparam logic [1:0] c_REL_EQ = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_STABLE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Combinational compare
    // ------------------------------------------------------------------
    logic       w_gt;
    logic       w_eq;
    logic [1:0] w_rel;

`ifdef CMP_SIGNED_EN
    assign w_gt = ($signed(a) > $signed(b));
`else
    assign w_gt = (a > b);
`endif
    assign w_eq  = (a == b);
    assign w_rel = w_gt ? c_REL_GT : (w_eq ? c_REL_EQ : c_REL_LT);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == c_CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // ------------------------------------------------------------------
    // Status flags, relation and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            q      <= 2'b00;
            rel    <= c_REL_LT;
            gt_cnt <= '0;
            eq_cnt <= '0;
            lt_cnt <= '0;
        end else if (en) begin
            // Level mode loads the flags; toggle mode flips them, resuming
            // from whatever q currently holds after a mode change.
            if (mode) begin
                q <= {w_eq, w_gt};
            end else begin
                q <= q ^ {w_eq, w_gt};
            end
            rel <= w_rel;
            if (w_gt) begin
                gt_cnt <= sat_inc(gt_cnt);
            end else if (w_eq) begin
                eq_cnt <= sat_inc(eq_cnt);
            end else begin
                lt_cnt <= sat_inc(lt_cnt);
            end
        end
    end

    // ------------------------------------------------------------------
    // Run-length FSM
    // ------------------------------------------------------------------
    state_t               r_state;
    logic [1:0]           r_last_rel;
    logic [c_RUN_W-1:0]   r_run_len;
    logic                 w_same;
    logic [c_RUN_W-1:0]   w_run_inc;

    assign w_same    = (w_rel == r_last_rel);
    assign w_run_inc = r_run_len + c_RUN_ONE;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_state    <= S_IDLE;
            r_last_rel <= c_REL_LT;
            r_run_len  <= '0;
            stable     <= 1'b0;
        end else if (en) begin
            case (r_state)
                S_IDLE: begin
                    r_last_rel <= w_rel;
                    r_run_len  <= c_RUN_ONE;
                    r_state    <= c_ONE_SHOT ? S_STABLE : S_RUN;
                    stable     <= c_ONE_SHOT;
                end
                S_RUN: begin
                    if (w_same) begin
                        r_run_len <= w_run_inc;
                        if (w_run_inc == c_RUN_TARGET) begin
                            r_state <= S_STABLE;
                            stable  <= 1'b1;
                        end
                    end else begin
                        r_last_rel <= w_rel;
                        r_run_len  <= c_RUN_ONE;
                        r_state    <= c_ONE_SHOT ? S_STABLE : S_RUN;
                        stable     <= c_ONE_SHOT;
                    end
                end
                S_STABLE: begin
                    // A repeated relation keeps the state; run_len holds.
                    if (!w_same) begin
                        r_last_rel <= w_rel;
                        r_run_len  <= c_RUN_ONE;
                        r_state    <= c_ONE_SHOT ? S_STABLE : S_RUN;
                        stable     <= c_ONE_SHOT;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_run_len <= '0;
                    stable    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cmp_toggle_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_cmp_toggle_tracker
// Description : Scoreboard bench for cmp_toggle_tracker. Two instances share
//               the stimulus: the default configuration, and a narrow one
//               (CNT_W=2, STABLE_N=1) to exercise counter saturation and the
//               single-sample stable case. A reference model derived from
//               the relation rules pushes expected outputs into a queue; a
//               monitor pops and compares one cycle later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cmp_toggle_tracker;

    localparam int WIDTH     = 4;
    localparam int CNT_W     = 8;
    localparam int STABLE_N  = 3;
    localparam int CNT_W2    = 2;
    localparam int STABLE_N2 = 1;

    logic             clk   = 1'b0;
    logic             reset = 1'b1;
    logic             en    = 1'b0;
    logic             clr   = 1'b0;
    logic             mode  = 1'b0;
    logic [WIDTH-1:0] a     = '0;
    logic [WIDTH-1:0] b     = '0;

    logic [1:0]        q, rel, q2, rel2;
    logic [CNT_W-1:0]  gt_cnt, eq_cnt, lt_cnt;
    logic [CNT_W2-1:0] gt_cnt2, eq_cnt2, lt_cnt2;
    logic              stable, stable2;

    always #5 clk = ~clk;

    cmp_toggle_tracker #(.WIDTH(WIDTH), .CNT_W(CNT_W), .STABLE_N(STABLE_N)) dut (
        .clk(clk), .reset(reset), .en(en), .clr(clr), .mode(mode),
        .a(a), .b(b), .q(q), .rel(rel),
        .gt_cnt(gt_cnt), .eq_cnt(eq_cnt), .lt_cnt(lt_cnt), .stable(stable)
    );

    cmp_toggle_tracker #(.WIDTH(WIDTH), .CNT_W(CNT_W2), .STABLE_N(STABLE_N2)) dut2 (
        .clk(clk), .reset(reset), .en(en), .clr(clr), .mode(mode),
        .a(a), .b(b), .q(q2), .rel(rel2),
        .gt_cnt(gt_cnt2), .eq_cnt(eq_cnt2), .lt_cnt(lt_cnt2), .stable(stable2)
    );

    // ------------------------------------------------------------------
    // Reference model state (plain integers, independent of RTL encoding)
    // ------------------------------------------------------------------
    typedef struct {
        logic [1:0] q;
        logic [1:0] rel;
        int         gt;
        int         eq;
        int         lt;
        int         run;
    } exp_t;

    exp_t       sb[$];
    logic [1:0] m_q    = 2'b00;
    logic [1:0] m_rel  = 2'b00;
    int         m_gt   = 0;
    int         m_eq   = 0;
    int         m_lt   = 0;
    int         m_run  = 0;
    logic [1:0] m_last = 2'b00;

    int checks = 0;
    int errors = 0;

    function automatic logic [1:0] ref_rel(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        int xv;
        int yv;
        xv = int'(x);
        yv = int'(y);
`ifdef CMP_SIGNED_EN
        if (xv >= 2 ** (WIDTH - 1)) xv = xv - 2 ** WIDTH;
        if (yv >= 2 ** (WIDTH - 1)) yv = yv - 2 ** WIDTH;
`endif
        if (xv > yv)  return 2'b01;
        if (xv == yv) return 2'b10;
        return 2'b00;
    endfunction

    function automatic int sat(input int v, input int bits);
        int mx;
        mx = (1 << bits) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs and record what the outputs must become.
    task automatic step(input logic rs, input logic cl, input logic ev, input logic md,
                        input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
        exp_t       e;
        logic [1:0] r;
        @(negedge clk);
        reset = rs; clr = cl; en = ev; mode = md; a = av; b = bv;
        if (rs || cl) begin
            m_q = 2'b00; m_rel = 2'b00; m_gt = 0; m_eq = 0; m_lt = 0;
            m_run = 0; m_last = 2'b00;
        end else if (ev) begin
            r = ref_rel(av, bv);
            if (md) m_q = {r == 2'b10, r == 2'b01};
            else    m_q = m_q ^ {r == 2'b10, r == 2'b01};
            m_rel = r;
            if (r == 2'b01)      m_gt++;
            else if (r == 2'b10) m_eq++;
            else                 m_lt++;
            m_run  = (m_run > 0 && r == m_last) ? m_run + 1 : 1;
            m_last = r;
        end
        e.q = m_q; e.rel = m_rel; e.gt = m_gt; e.eq = m_eq; e.lt = m_lt; e.run = m_run;
        sb.push_back(e);
    endtask

    // ------------------------------------------------------------------
    // Monitor: compares one cycle after each recorded stimulus
    // ------------------------------------------------------------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("q",       int'(q),       int'(e.q));
                check("rel",     int'(rel),     int'(e.rel));
                check("gt_cnt",  int'(gt_cnt),  sat(e.gt, CNT_W));
                check("eq_cnt",  int'(eq_cnt),  sat(e.eq, CNT_W));
                check("lt_cnt",  int'(lt_cnt),  sat(e.lt, CNT_W));
                check("stable",  int'(stable),  int'(e.run >= STABLE_N));
                check("q2",      int'(q2),      int'(e.q));
                check("rel2",    int'(rel2),    int'(e.rel));
                check("gt_cnt2", int'(gt_cnt2), sat(e.gt, CNT_W2));
                check("eq_cnt2", int'(eq_cnt2), sat(e.eq, CNT_W2));
                check("lt_cnt2", int'(lt_cnt2), sat(e.lt, CNT_W2));
                check("stable2", int'(stable2), int'(e.run >= STABLE_N2));
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [WIDTH-1:0] av;
        logic [WIDTH-1:0] bv;
        logic             md;

        // Reset with live operands and enable.
        step(1, 0, 1, 0, 4'd10, 4'd5);

        // Toggle mode, four GT samples.
        step(0, 0, 1, 0, 4'd10, 4'd5);
        step(0, 0, 1, 0, 4'd11, 4'd9);
        step(0, 0, 1, 0, 4'd9,  4'd1);
        step(0, 0, 1, 0, 4'd10, 4'd1);

        // Level mode after a clear: EQ, GT, LT.
        step(0, 1, 1, 1, 4'd0, 4'd0);
        step(0, 0, 1, 1, 4'd7, 4'd7);
        step(0, 0, 1, 1, 4'd7, 4'd5);
        step(0, 0, 1, 1, 4'd2, 4'd9);

        // Five EQ samples in toggle mode: narrow counter saturates.
        step(0, 1, 0, 0, 4'd0, 4'd0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 4'd3, 4'd3);

        // Run interrupted by idle cycles, then clr wins over en.
        step(0, 1, 0, 0, 4'd0, 4'd0);
        step(0, 0, 1, 0, 4'd6, 4'd2);
        step(0, 0, 1, 0, 4'd6, 4'd2);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 4'd1, 4'd9);
        step(0, 0, 1, 0, 4'd6, 4'd2);
        step(0, 0, 1, 0, 4'd6, 4'd2);
        step(0, 1, 1, 0, 4'd6, 4'd2);

        // Signedness boundary: 4'b1000 vs 4'b0111.
        step(0, 0, 1, 0, 4'b1000, 4'b0111);
        step(0, 0, 1, 0, 4'b0111, 4'b1000);

        // Randomised traffic with a bias toward small operands for long runs.
        md = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 15) == 0) md = ~md;
            if ($urandom_range(0, 1) == 0) begin
                av = WIDTH'($urandom_range(0, 2));
                bv = WIDTH'($urandom_range(0, 2));
            end else begin
                av = WIDTH'($urandom);
                bv = WIDTH'($urandom);
            end
            step($urandom_range(0, 199) == 0, $urandom_range(0, 59) == 0,
                 $urandom_range(0, 3) != 0, md, av, bv);
        end

        // Let the monitor drain, bounded.
        @(negedge clk);
        en = 1'b0; clr = 1'b0; reset = 1'b0;
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
